// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the uart_tx block: line-level constants, the FSM
// state encoding and a helper that sizes the bit counter.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> the PARITY state exists and frames may carry a parity bit
//   undefined -> no PARITY state, every frame is start + data + stop
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } tx_state_e;
`endif

    // Bit counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
// Frame sequencer for uart_tx: IDLE -> START -> DATA x DATA_WIDTH
// -> [PARITY] -> STOP -> IDLE, plus the data bit counter.
//
// The next-state and next-count values are exported so the top can register
// the serial line and busy flag from them, keeping both outputs as true flops
// aligned with the state register.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   load       : accept strobe (already qualified with !busy by the top)
//   par_en     : captured parity enable (only with UART_TX_PARITY_EN)
//   state_nxt  : state the FSM enters at the next edge
//   cnt_nxt    : data bit index the FSM holds after the next edge
//
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
`ifdef UART_TX_PARITY_EN
    input  logic             par_en,
`endif
    output tx_state_e        state_nxt,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) state_nxt = START;
            end
            START: begin
                // Counter cleared on the way into DATA so bit 0 goes first.
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_nxt = STOP;
`endif
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial transmitter, one bit per clock (no baud divider). Frame on the line:
// start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Parity bit: XNOR-reduce of the data when PAR_TYP_TOP=0, XOR-reduce when 1.
//
// Ports
//   CLK_TOP        : clock, rising edge
//   RST_TOP        : synchronous active-high reset (aborts any frame)
//   P_DATA_TOP     : word to transmit, sampled on an accepted strobe
//   Data_Valid_TOP : load strobe, honoured only while busy_TOP=0
//   PAR_EN_TOP     : parity enable, sampled with the word
//   PAR_TYP_TOP    : parity type, sampled with the word
//   TX_OUT_TOP     : registered serial line, idles high
//   busy_TOP       : registered, high from start bit through stop bit
//
// Optional feature macro: UART_TX_PARITY_EN
//   undefined -> PAR_EN_TOP / PAR_TYP_TOP are ignored, no parity logic
// ---------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_TOP,
    input  logic                  RST_TOP,
    input  logic [DATA_WIDTH-1:0] P_DATA_TOP,
    input  logic                  Data_Valid_TOP,
    input  logic                  PAR_EN_TOP,
    input  logic                  PAR_TYP_TOP,
    output logic                  TX_OUT_TOP,
    output logic                  busy_TOP
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  tx_nxt;
    logic                  accept;
    tx_state_e             state_nxt;
    logic [CNT_W-1:0]      cnt_nxt;

    // busy_q mirrors (state != IDLE), so it is the idle qualifier for loads.
    // Reset overrides everything below, so a strobe under reset is dropped.
    assign accept = Data_Valid_TOP && !busy_q;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    assign par_bit = par_typ_q ? (^data_q) : (~^data_q);
`else
    logic unused_par_inputs;
    assign unused_par_inputs = PAR_EN_TOP | PAR_TYP_TOP;
`endif

    uart_tx_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_fsm (
        .clk       (CLK_TOP),
        .rst       (RST_TOP),
        .load      (accept),
`ifdef UART_TX_PARITY_EN
        .par_en    (par_en_q),
`endif
        .state_nxt (state_nxt),
        .cnt_nxt   (cnt_nxt)
    );

    // Frame parameters are frozen at acceptance; later input changes cannot
    // reach the frame in flight.
    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            data_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else if (accept) begin
            data_q    <= P_DATA_TOP;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN_TOP;
            par_typ_q <= PAR_TYP_TOP;
`endif
        end
    end

    // Line value decoded from the state being entered, so the registered
    // output lines up with the FSM state of the same cycle. In the cycle
    // that enters DATA, data_q was captured one edge earlier (at START).
    always_comb begin
        tx_nxt = IDLE_LEVEL;
        case (state_nxt)
            IDLE:    tx_nxt = IDLE_LEVEL;
            START:   tx_nxt = START_BIT;
            DATA:    tx_nxt = data_q[cnt_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nxt = par_bit;
`endif
            STOP:    tx_nxt = STOP_BIT;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            tx_q   <= IDLE_LEVEL;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    assign TX_OUT_TOP = tx_q;
    assign busy_TOP   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx (DATA_WIDTH=8): a table of frames with
// hand-computed parity bits, plus hand-written sequences for the literal
// 0xC8 waveform, strobes during a frame, and reset during a frame.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       dv;
    logic       par_en;
    logic       par_typ;
    logic       tx;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic       en;
        logic       typ;
        logic       exp_par;
    } vec_t;

    vec_t vecs[10];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK_TOP        (clk),
        .RST_TOP        (rst),
        .P_DATA_TOP     (p_data),
        .Data_Valid_TOP (dv),
        .PAR_EN_TOP     (par_en),
        .PAR_TYP_TOP    (par_typ),
        .TX_OUT_TOP     (tx),
        .busy_TOP       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one frame and walk it bit by bit. Inputs are scrambled right after
    // acceptance so a design that re-samples them mid-frame is caught.
    task automatic run_frame(input logic [7:0] d, input logic en, input logic typ,
                             input logic exp_par, input string tag);
        chk({tag, " busy before strobe"}, busy, 1'b0);
        p_data  = d;
        par_en  = en;
        par_typ = typ;
        dv      = 1'b1;
        step();
        dv      = 1'b0;
        p_data  = ~d;
        par_en  = ~en;
        par_typ = ~typ;
        chk({tag, " start tx"}, tx, 1'b0);
        chk({tag, " start busy"}, busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("%s data%0d tx", tag, i), tx, d[i]);
            chk($sformatf("%s data%0d busy", tag, i), busy, 1'b1);
        end
        if (HAS_PAR && en) begin
            step();
            chk({tag, " parity tx"}, tx, exp_par);
            chk({tag, " parity busy"}, busy, 1'b1);
        end
        step();
        chk({tag, " stop tx"}, tx, 1'b1);
        chk({tag, " stop busy"}, busy, 1'b1);
        step();
        chk({tag, " idle tx"}, tx, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 0xC8 on the line: start, 0,0,0,1,0,0,1,1, stop
        logic exp_seq [10];
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        //          data   en    typ   parity (hand-computed)
        vecs[0] = '{8'hC8, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hC8, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'hA1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hF3, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h31, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{8'h5A, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; dv = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        step();
        step();
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        step();
        chk("post-reset tx", tx, 1'b1);
        chk("post-reset busy", busy, 1'b0);

        // Literal waveform for 0xC8 without parity, PAR_TYP both ways.
        for (int t = 0; t < 2; t++) begin
            p_data = 8'hC8; par_en = 1'b0; par_typ = t[0]; dv = 1'b1;
            step();
            dv = 1'b0;
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("c8 typ%0d bit%0d tx", t, k), tx, exp_seq[k]);
                chk($sformatf("c8 typ%0d bit%0d busy", t, k), busy, 1'b1);
                step();
            end
            chk($sformatf("c8 typ%0d end tx", t), tx, 1'b1);
            chk($sformatf("c8 typ%0d end busy", t), busy, 1'b0);
        end

        for (int i = 0; i < 10; i++)
            run_frame(vecs[i].data, vecs[i].en, vecs[i].typ, vecs[i].exp_par,
                      $sformatf("vec%0d", i));

        // Strobes mid-data and during the stop bit are dropped.
        p_data = 8'hC8; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("midstrobe bit%0d tx", k), tx, exp_seq[k]);
            chk($sformatf("midstrobe bit%0d busy", k), busy, 1'b1);
            if (k == 2 || k == 9) begin
                p_data = 8'h55; par_en = 1'b1; dv = 1'b1;
            end else begin
                dv = 1'b0;
            end
            step();
        end
        dv = 1'b0;
        chk("midstrobe end tx", tx, 1'b1);
        chk("midstrobe end busy", busy, 1'b0);
        step();
        chk("midstrobe dropped tx", tx, 1'b1);
        chk("midstrobe dropped busy", busy, 1'b0);

        // Reset during data bits of 0x00 (line low), with a strobe under reset.
        p_data = 8'h00; par_en = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        step();
        step();
        chk("prereset data tx", tx, 1'b0);
        chk("prereset busy", busy, 1'b1);
        rst = 1'b1; dv = 1'b1; p_data = 8'h00;
        step();
        chk("abort tx", tx, 1'b1);
        chk("abort busy", busy, 1'b0);
        rst = 1'b0; dv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("after abort %0d tx", k), tx, 1'b1);
            chk($sformatf("after abort %0d busy", k), busy, 1'b0);
        end

        run_frame(8'hA1, 1'b1, 1'b1, 1'b1, "post-abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the parallel data width in bits.
REQ-002 SHALL have port CLK_TOP, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 SHALL have port RST_TOP, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port P_DATA_TOP, input, DATA_WIDTH, the parallel word to transmit.
REQ-005 SHALL have port Data_Valid_TOP, input, 1, a one-cycle load strobe for P_DATA_TOP.
REQ-006 SHALL have port PAR_EN_TOP, input, 1, parity enable (1 = parity bit inserted).
REQ-007 SHALL have port PAR_TYP_TOP, input, 1, parity type select.
REQ-008 SHALL have port TX_OUT_TOP, output, 1, serial line; idle level 1.
REQ-009 SHALL have port busy_TOP, output, 1, high while a frame is on the line.

Function
REQ-010 SHALL transmit one bit per CLK_TOP cycle, with no baud divider.
REQ-011 SHALL send each frame as: start bit 0, then DATA_WIDTH data bits LSB first, then the parity bit if enabled, then stop bit 1.
REQ-012 SHALL compute the parity bit as XNOR-reduction of the data when PAR_TYP_TOP=0, and as XOR-reduction of the data when PAR_TYP_TOP=1.
REQ-013 SHALL accept Data_Valid_TOP=1 only while busy_TOP=0; on acceptance it captures P_DATA_TOP, PAR_EN_TOP and PAR_TYP_TOP into internal registers.
REQ-014 SHALL drive busy_TOP=1 and TX_OUT_TOP=0 (start bit) in the cycle after the acceptance edge, giving a latency of 1 cycle.
REQ-015 SHALL hold every bit on TX_OUT_TOP for exactly one cycle; the frame lasts DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without.
REQ-016 SHALL keep busy_TOP=1 through the stop-bit cycle, then return to busy_TOP=0 and TX_OUT_TOP=1 in the next cycle.
REQ-017 SHALL ignore Data_Valid_TOP asserted while busy_TOP=1, including during the stop bit; the frame in progress is unaffected.
REQ-018 SHALL NOT let changes on P_DATA_TOP, PAR_EN_TOP or PAR_TYP_TOP during a frame affect that frame.
REQ-019 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-020 The FSM SHALL take these transitions: IDLE->START on accept; START->DATA; DATA->DATA until the bit counter reaches DATA_WIDTH-1; DATA->PARITY if the parity enable was captured as 1, otherwise DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-021 SHALL size the bit counter as $clog2(DATA_WIDTH) bits and clear it on entry to DATA.
REQ-022 SHALL register both TX_OUT_TOP and busy_TOP, with no combinational path from any input to any output.

Reset
REQ-023 When RST_TOP=1 at a rising edge, the block SHALL go to IDLE and set TX_OUT_TOP=1, busy_TOP=0, and clear the counter and data registers.
REQ-024 A reset during a frame SHALL abort the frame immediately, driving the line to 1 on the next cycle; no partial frame resumes afterwards.
REQ-025 SHALL ignore Data_Valid_TOP in any cycle where RST_TOP=1.

Configuration
REQ-026 Parity support SHALL be compiled in when the macro UART_TX_PARITY_EN is defined; with it, behaviour follows REQ-012 and REQ-020.
REQ-027 Without UART_TX_PARITY_EN, PAR_EN_TOP and PAR_TYP_TOP SHALL be ignored, the PARITY state and parity logic SHALL be absent, and every frame SHALL be DATA_WIDTH+2 bits.

Structure
REQ-028 The state enum and the START_BIT=1'b0, STOP_BIT=1'b1 and IDLE_LEVEL=1'b1 constants SHALL live in the shared package uart_tx_pkg.
REQ-029 The FSM and bit counter SHALL be a single sub-module, uart_tx_fsm; the data/parity registers and output mux SHALL remain in uart_tx.

Verification
REQ-030 Load 0xC8 with PAR_EN=0 -> TX sequence 0,0,0,0,1,0,0,1,1,1 (10 cycles), then TX=1 and busy=0.
REQ-031 Load 0xC8 with PAR_EN=0 and PAR_TYP=1 -> output identical to REQ-030, confirming PAR_TYP is ignored when parity is disabled.
REQ-032 Load 0xA1 with PAR_EN=1 and PAR_TYP=1 -> 0,1,0,0,0,0,1,0,1, parity 1, stop 1 (11 cycles); load 0xF3 with PAR_EN=1 and PAR_TYP=0 -> parity bit 1.
REQ-033 Load 0x31 with PAR_TYP=1 and 0x33 with PAR_TYP=0, both with PAR_EN=1 -> parity bit 1 in each frame; busy rises 1 cycle after the strobe.
REQ-034 Pulse Data_Valid mid-frame with a different word -> current frame unchanged and the pulse dropped; assert RST_TOP mid-frame -> TX=1 and busy=0 on the next cycle.
